// File: rtl/clu_pkg.sv
// clu_pkg: aluop/source/writeback encodings, opcode field positions and FSM state type shared by clu_pipe and clu_regfile
package clu_pkg;
  localparam int AW = 5;
  localparam int F_SRCA = 0;
  localparam int F_SRCB = 2;
  localparam int F_WB = 4;
  localparam int F_ALU = 6;
  localparam int F_REGA = 10;
  localparam int F_REGB = 15;
  localparam int F_DST = 20;
  localparam int F_DST2 = 25;
  localparam int F_RSVD = 30;
  localparam int F_EN = 31;
  typedef enum logic [1:0] {
    SRC_REG  = 2'b00,
    SRC_HOLD = 2'b01,
    SRC_KEEP = 2'b10,
    SRC_IMM  = 2'b11
  } src_e;
  localparam logic [1:0] WB_WRITE = 2'b11;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SHL  = 4'h5,
    ALU_SHR  = 4'h6,
    ALU_MUL  = 4'h7,
    ALU_NOT  = 4'h8,
    ALU_PASS = 4'h9,
    ALU_DIV  = 4'hA
  } alu_e;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_SRCA = 3'd1;
  localparam state_t ST_SRCB = 3'd2;
  localparam state_t ST_EXEC = 3'd3;
  localparam state_t ST_WB0  = 3'd4;
  localparam state_t ST_WB1  = 3'd5;
endpackage

// File: rtl/clu_regfile.sv
// clu_regfile: NREG x DW registers; clk/rst_n, async reads ra1->rd1 and ra2->rd2 (0 when index >= NREG), sync write we/wa/wd (dropped when wa >= NREG)
module clu_regfile import clu_pkg::*; #(
  parameter int DW = 64,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);
  logic [DW-1:0] mem [NREG];
  assign rd1 = 32'(ra1) < NREG ? mem[ra1] : '0;
  assign rd2 = 32'(ra2) < NREG ? mem[ra2] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we && 32'(wa) < NREG)
      mem[wa] <= wd;
endmodule

// File: rtl/clu_pipe.sv
// clu_pipe: multi-cycle opcode unit; clk/rst_n, op_valid/op_ready/opcode/a/b in, in1/in2 operands, result/result1/cflag/zflag ALU outputs, done retire pulse
module clu_pipe import clu_pkg::*; #(
  parameter int DW = 64,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [31:0]   opcode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] in1,
  output logic [DW-1:0] in2,
  output logic [DW-1:0] result,
  output logic [DW-1:0] result1,
  output logic          cflag,
  output logic          zflag,
  output logic          done
);
  localparam int SH = $clog2(DW);
  state_t st;
  logic [31:0] op_q;
  logic [DW-1:0] a_q, b_q, rd1, rd2, wd, alu_r, alu_r1;
  logic [DW:0] sum;
  logic [2*DW-1:0] prod;
  logic [1:0] srca, srcb, wbm;
  logic [3:0] aluop;
  logic [AW-1:0] rega, regb, dst, dst2, wa;
  logic alu_c, we, dual, unused_rsvd;
  assign srca = op_q[F_SRCA +: 2];
  assign srcb = op_q[F_SRCB +: 2];
  assign wbm = op_q[F_WB +: 2];
  assign aluop = op_q[F_ALU +: 4];
  assign rega = op_q[F_REGA +: AW];
  assign regb = op_q[F_REGB +: AW];
  assign dst = op_q[F_DST +: AW];
  assign dst2 = op_q[F_DST2 +: AW];
  assign unused_rsvd = op_q[F_RSVD];
  assign dual = aluop == ALU_MUL || aluop == ALU_DIV;
  assign op_ready = st == ST_IDLE;
  assign we = (st == ST_SRCA && srca == SRC_IMM) || (st == ST_SRCB && srcb == SRC_IMM) || st == ST_WB0 || st == ST_WB1;
  assign wa = st == ST_SRCA ? rega : st == ST_SRCB ? regb : st == ST_WB0 ? dst : dst2;
  assign wd = st == ST_SRCA ? a_q : st == ST_SRCB ? b_q : st == ST_WB0 ? result : result1;
  clu_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk(clk), .rst_n(rst_n), .ra1(rega), .ra2(regb), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd)
  );
  assign sum = {1'b0, in1} + {1'b0, in2};
  assign prod = {{DW{1'b0}}, in1} * {{DW{1'b0}}, in2};
  always_comb begin
    alu_r = '0;
    alu_r1 = '0;
    alu_c = 1'b0;
    case (aluop)
      ALU_ADD: {alu_c, alu_r} = sum;
      ALU_SUB: begin
        alu_r = in1 - in2;
        alu_c = in1 < in2;
      end
      ALU_AND: alu_r = in1 & in2;
      ALU_OR: alu_r = in1 | in2;
      ALU_XOR: alu_r = in1 ^ in2;
      ALU_SHL: alu_r = in1 << in2[SH-1:0];
      ALU_SHR: alu_r = in1 >> in2[SH-1:0];
      ALU_MUL: {alu_r1, alu_r} = prod;
      ALU_NOT: alu_r = ~in1;
      ALU_PASS: alu_r = in1;
      ALU_DIV: begin
        alu_r = in2 == '0 ? '1 : in1 / in2;
        alu_r1 = in2 == '0 ? in1 : in1 % in2;
        alu_c = in2 == '0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= ST_IDLE;
      done <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      in1 <= '0;
      in2 <= '0;
      result <= '0;
      result1 <= '0;
      cflag <= 1'b0;
      zflag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        ST_IDLE: if (op_valid) begin
          op_q <= opcode;
          a_q <= a;
          b_q <= b;
          st <= ST_SRCA;
        end
        ST_SRCA: begin
          in1 <= srca == SRC_IMM ? a_q : srca == SRC_REG ? rd1 : in1;
          st <= ST_SRCB;
        end
        ST_SRCB: begin
          in2 <= srcb == SRC_IMM ? b_q : srcb == SRC_REG ? rd2 : in2;
          st <= op_q[F_EN] ? ST_EXEC : ST_IDLE;
          done <= !op_q[F_EN];
        end
        ST_EXEC: begin
          result <= alu_r;
          result1 <= alu_r1;
          cflag <= alu_c;
          zflag <= alu_r == '0;
          st <= wbm == WB_WRITE ? ST_WB0 : ST_IDLE;
          done <= wbm != WB_WRITE;
        end
        ST_WB0: begin
          st <= dual ? ST_WB1 : ST_IDLE;
          done <= !dual;
        end
        ST_WB1: begin
          st <= ST_IDLE;
          done <= 1'b1;
        end
        default: st <= ST_IDLE;
      endcase
    end
endmodule
